// File: rtl/trimmed_mean_calc.sv
// Alpha-trimmed mean core: gathers the middle DN-2*TRIM ranked samples and outputs their rounded mean.
// Latency KEEP+SW+1 cycles from accepted start to the mean_valid cycle; start is ignored while busy.
module trimmed_mean_calc #(
   parameter int DN          = 25,
   parameter int DW          = 8,
   parameter int DW_sequence = $clog2(DN),
   parameter int TRIM        = 6
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [DW*DN-1:0]          data_unsort,
   input  logic [DW_sequence*DN-1:0] sequence_sorted,
   output logic [DW-1:0]             mean_out,
   output logic                      mean_valid,
   output logic                      busy,
   output logic                      range_err
);

   localparam int KEEP  = DN - 2*TRIM;
   localparam int SW    = DW + DW_sequence;
   localparam int BW    = $clog2(SW + 1);
   localparam int NSLOT = 1 << DW_sequence;

   localparam logic [DW_sequence-1:0] K_FIRST  = DW_sequence'(TRIM);
   localparam logic [DW_sequence-1:0] K_LAST   = DW_sequence'(DN - TRIM - 1);
   localparam logic [DW_sequence:0]   DN_C     = (DW_sequence+1)'(DN);
   localparam logic [SW-1:0]          KEEP_S   = SW'(KEEP);
   localparam logic [SW-1:0]          BIAS     = SW'(KEEP / 2);
   localparam logic [BW-1:0]          BIT_LAST = BW'(SW - 1);

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DIV, S_DONE} state_t;

   state_t                    r_state;
   state_t                    w_next;
   logic [DW*DN-1:0]          r_data;
   logic [DW_sequence*DN-1:0] r_seq;
   logic [DW_sequence-1:0]    r_k;
   logic [SW-1:0]             r_sum;
   logic [SW-1:0]             r_rem;
   logic [BW-1:0]             r_bit;
   logic [DW-1:0]             r_mean;
   logic                      r_range_err;

   logic [DW-1:0]          w_samp [NSLOT];
   logic [DW_sequence-1:0] w_slot [NSLOT];
   logic [DW_sequence-1:0] w_idx;
   logic                   w_idx_ok;
   logic [DW-1:0]          w_gath;
   logic [SW-1:0]          w_sum_acc;
   logic                   w_accum_last;
   logic [SW:0]            w_trial;
   logic                   w_ge;
   logic [SW-1:0]          w_diff;
   logic [SW-1:0]          w_quot;
   logic                   w_div_last;

   // Pad both lookup tables to a power of two so any index value selects something defined.
   for (genvar g = 0; g < NSLOT; g++) begin : g_unpack
      if (g < DN) begin : g_live
         assign w_samp[g] = r_data[g*DW +: DW];
         assign w_slot[g] = r_seq[g*DW_sequence +: DW_sequence];
      end else begin : g_pad
         assign w_samp[g] = '0;
         assign w_slot[g] = '0;
      end
   end

   assign w_idx        = w_slot[r_k];
   assign w_idx_ok     = ({1'b0, w_idx} < DN_C);
   assign w_gath       = w_idx_ok ? w_samp[w_idx] : '0;
   assign w_sum_acc    = r_sum + {{(SW-DW){1'b0}}, w_gath};
   assign w_accum_last = (r_k == K_LAST);

   // Restoring division: r_sum shifts the dividend out at the top and the quotient in at the bottom.
   assign w_trial    = {r_rem, r_sum[SW-1]};
   assign w_ge       = (w_trial >= {1'b0, KEEP_S});
   assign w_diff     = w_trial[SW-1:0] - KEEP_S;
   assign w_quot     = {r_sum[SW-2:0], w_ge};
   assign w_div_last = (r_bit == BIT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_ACCUM;
         S_ACCUM: if (w_accum_last) w_next = S_DIV;
         S_DIV:   if (w_div_last) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy       = (r_state != S_IDLE);
      mean_valid = (r_state == S_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data      <= '0;
         r_seq       <= '0;
         r_k         <= '0;
         r_sum       <= '0;
         r_rem       <= '0;
         r_bit       <= '0;
         r_mean      <= '0;
         r_range_err <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_data      <= data_unsort;
                  r_seq       <= sequence_sorted;
                  r_k         <= K_FIRST;
                  r_sum       <= '0;
                  r_rem       <= '0;
                  r_bit       <= '0;
                  r_range_err <= 1'b0;
               end
            end
            S_ACCUM: begin
               r_k   <= r_k + 1'b1;
               r_sum <= w_accum_last ? (w_sum_acc + BIAS) : w_sum_acc;
               if (!w_idx_ok) r_range_err <= 1'b1;
            end
            S_DIV: begin
               r_rem <= w_ge ? w_diff : w_trial[SW-1:0];
               r_sum <= w_quot;
               r_bit <= r_bit + 1'b1;
               if (w_div_last) r_mean <= w_quot[DW-1:0];
            end
            default: ;
         endcase
      end
   end

   assign mean_out  = r_mean;
   assign range_err = r_range_err;

endmodule

// File: doc/trimmed_mean_calc.md
Name: trimmed_mean_calc

Overview:
Consumer of the parallel sorter's rank output. Uses the sorted-index vector to gather the middle (DN-2*TRIM) samples of a window and outputs their rounded mean. This is the modified alpha-trimmed mean filter core.
Sits directly after parallel_sort in the filter datapath. The top level drives start from sort_finish delayed by one clock, so sequence_sorted is already updated when start is sampled.

Parameters:
DN, 25, samples per window
DW, 8, sample width
DW_sequence, $clog2(DN), index width
TRIM, 6, samples discarded at each end; 2*TRIM < DN required
(derived) KEEP = DN-2*TRIM = 13; SW = DW+DW_sequence = 13, the accumulator/divider width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle strobe; data_unsort and sequence_sorted must be valid in this cycle
data_unsort  in  DW*DN  window samples; sample i is at [i*DW+:DW]
sequence_sorted  in  DW_sequence*DN  slot k holds the original index of the k-th smallest sample (slot 0 = smallest)
mean_out  out  DW  trimmed mean; held until the next result
mean_valid  out  1  one-cycle pulse when mean_out updates
busy  out  1  high from start acceptance until return to IDLE
range_err  out  1  set if any gathered index >= DN in the current operation; cleared on the next accepted start

Behaviour:
- Reset (asynchronous, any state): FSM to IDLE; mean_out=0, mean_valid=0, busy=0, range_err=0; all internal registers 0.
- FSM states: IDLE -> ACCUM -> DIV -> DONE -> IDLE.
- IDLE:
  - start=1 at an edge: register both input vectors, set k=TRIM, sum=0, clear range_err, go to ACCUM, set busy=1.
  - start is accepted only in IDLE. It is ignored in ACCUM, DIV and DONE, including the DONE cycle.
- ACCUM: lasts exactly KEEP cycles.
  - Each cycle: idx = seq[k]; sum += data[idx] (zero-extended to SW bits); k++.
  - Gathers slots TRIM..DN-TRIM-1.
  - idx >= DN: contributes 0 and sets range_err.
  - After the last slot: sum += KEEP>>1 (round-half-up bias), go to DIV.
- DIV: restoring divider, sum / KEEP, one quotient bit per cycle, exactly SW cycles, MSB first.
  - Remainder is discarded.
  - Quotient is always <= 2^DW-1; mean_out takes its low DW bits and no saturation logic is required.
- DONE: one cycle.
  - mean_out <= quotient, mean_valid=1.
  - busy stays 1 during DONE; the next edge goes to IDLE with busy=0 and mean_valid=0.
- Latency (defaults): start sampled at edge E0; mean_valid high for the one cycle following edge E0+KEEP+SW = E0+26; busy low after edge E0+27.
- Width rule: max sum = KEEP*(2^DW-1)+KEEP/2 = 3321, which fits SW bits. No overflow is possible for any legal parameter set.
- Inputs are captured at acceptance, so changes on data_unsort/sequence_sorted after the start edge have no effect.

Test Plan:
1. data all 100, sequence_sorted identity (slot k = k), start -> mean_valid pulse exactly 26 edges after the start edge, mean_out=100, range_err=0.
2. data[i]=10*i, identity order -> slots 6..18 sum 1560, (1560+6)/13 -> mean_out=120.
3. Rounding:
   - Middle slots hold twelve 10s and one 17 (outliers 0 and 255 in the trimmed slots), sum 137 -> mean_out=11.
   - Repeat with twelve 10s and one 15, sum 135 -> mean_out=10.
4. All samples 255 -> mean_out=255 with no overflow. Then an entry of 31 in slot 10 -> range_err=1, that slot contributes 0, (3060+6)/13 -> mean_out=235.
5. Second start pulsed during ACCUM and again in the DONE cycle -> both ignored, exactly one mean_valid. A start one cycle after busy falls is accepted.
6. rst asserted in ACCUM cycle 5 -> mean_out=0, busy=0, no mean_valid. A fresh start after release reproduces the result of scenario 2 (mean_out=120).
